// File: rtl/board_mem_slave.sv
// Avalon-MM slave board store: word-addressed memory with waitrequest backpressure,
// fixed-latency pipelined reads, optional periodic stall injection and traffic/error status.
module board_mem_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned WAIT_EVERY   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        addr_error
);

  localparam int unsigned LAT = READ_LATENCY;
  localparam int unsigned AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned OW  = 4;
  localparam int unsigned CW  = 16;

  typedef enum logic [1:0] {RESET_HOLD, READY, STALL, FULL} state_e;

  state_e          state_q, state_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic [31:0]     dat_q [LAT];
  logic [31:0]     dat_d [LAT];
  logic [OW-1:0]   out_q, out_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            err_q, err_d;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [29:0]     idx;
  logic [AW-1:0]   widx;
  logic            addr_ok;
  logic [31:0]     rd_data;
  logic            accept, wr_acc, rd_acc, stall_hit;

  // Address decode; BASE_ADDR is assumed word aligned
  assign idx     = slave_address[31:2] - BASE_ADDR[31:2];
  assign addr_ok = (slave_address >= BASE_ADDR) && (idx < 30'(DEPTH_WORDS)) &&
                   (slave_address[1:0] == 2'b00);
  assign widx    = idx[AW-1:0];
  assign rd_data = addr_ok ? mem[widx] : 32'h0;

  // A simultaneous read+write is a protocol violation: only the write is honoured
  assign slave_waitrequest = (state_q != READY);
  assign accept            = (slave_read | slave_write) & ~slave_waitrequest;
  assign wr_acc            = accept & slave_write;
  assign rd_acc            = accept & slave_read & ~slave_write;

  assign slave_readdata      = dat_q[LAT-1];
  assign slave_readdatavalid = vld_q[LAT-1];
  assign wr_count            = wr_cnt_q;
  assign rd_count            = rd_cnt_q;
  assign addr_error          = err_q;

  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    out_d    = out_q;
    acc_d    = acc_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    state_d  = READY;
    stall_hit = 1'b0;

    // Each stage keeps its last data so the output holds while valid is low
    vld_d[0] = rd_acc;
    if (rd_acc) dat_d[0] = rd_data;
    for (int i = 1; i < int'(LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end

    out_d = out_q + OW'(rd_acc) - OW'(vld_q[LAT-1]);

    if (WAIT_EVERY != 0) begin
      if (accept) begin
        if (acc_q == CW'(WAIT_EVERY - 1)) begin
          stall_hit = 1'b1;
          acc_d     = '0;
        end else begin
          acc_d = acc_q + CW'(1);
        end
      end
    end

    if (wr_acc && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CW'(1);
    if (vld_d[LAT-1] && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CW'(1);
    if (accept && (!addr_ok || (slave_read && slave_write))) err_d = 1'b1;

    // Full only blocks when no return frees a slot in the coming cycle
    if (stall_hit) begin
      state_d = STALL;
    end else if ((out_d == OW'(MAX_PENDING)) && !vld_d[LAT-1]) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RESET_HOLD;
      vld_q    <= '0;
      for (int i = 0; i < int'(LAT); i++) dat_q[i] <= 32'h0;
      out_q    <= '0;
      acc_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      for (int i = 0; i < int'(LAT); i++) dat_q[i] <= dat_d[i];
      out_q    <= out_d;
      acc_q    <= acc_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage survives reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc && addr_ok) mem[widx] <= slave_writedata;
  end

endmodule

// File: tb/tb_board_mem_slave.sv
// Bench for board_mem_slave: three differently parameterised instances, directed scenarios
// and random traffic, each instance shadowed by a queue-based transaction model.
module tb_board_mem_slave;

  function automatic logic [31:0] base_of(input int g);
    if (g == 0) return 32'h0000_0000;
    if (g == 1) return 32'h0000_8000;
    return 32'h1000_0000;
  endfunction
  function automatic int unsigned depth_of(input int g); return (g == 2) ? 256 : 1024; endfunction
  function automatic int unsigned lat_of(input int g);   return (g == 1) ? 6 : 2;      endfunction
  function automatic int unsigned we_of(input int g);    return (g == 2) ? 3 : 0;      endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_at_edge = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [2:0]       rd, wr, wreq, rvld, aerr;
  logic [2:0][31:0] addr, wdata, rdata;
  logic [2:0][15:0] wrc, rdc;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam logic [31:0] LB = base_of(g);
    localparam int unsigned LD = depth_of(g);
    localparam int unsigned LL = lat_of(g);
    localparam int unsigned LW = we_of(g);

    board_mem_slave #(
      .BASE_ADDR(LB), .DEPTH_WORDS(LD), .READ_LATENCY(LL), .MAX_PENDING(4), .WAIT_EVERY(LW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .slave_waitrequest(wreq[g]), .slave_address(addr[g]),
      .slave_read(rd[g]), .slave_readdata(rdata[g]), .slave_readdatavalid(rvld[g]),
      .slave_write(wr[g]), .slave_writedata(wdata[g]), .wr_count(wrc[g]),
      .rd_count(rdc[g]), .addr_error(aerr[g])
    );

    logic [31:0] mmem [1024];
    logic [31:0] qd [$];
    int          qt [$];
    int          macc, mwr, mrd;
    bit          st_now, merr;

    // Model: a queue of (snapshot data, due cycle) per accepted read, memory as an array
    always @(negedge clk) begin : mon
      bit ev, ok;
      logic [31:0] a;
      if (rst_at_edge !== 1'b1) begin
        chk($sformatf("g%0d_reset_wait", g), 32'(wreq[g]), 32'd1);
        chk($sformatf("g%0d_reset_valid", g), 32'(rvld[g]), 32'd0);
        chk($sformatf("g%0d_reset_rdata", g), rdata[g], 32'd0);
        chk($sformatf("g%0d_reset_counts", g), {rdc[g], wrc[g]}, 32'd0);
        chk($sformatf("g%0d_reset_err", g), 32'(aerr[g]), 32'd0);
        qd.delete(); qt.delete();
        macc = 0; mwr = 0; mrd = 0; st_now = 0; merr = 0;
      end else begin
        ev = (qt.size() != 0) && (qt[0] == cyc);
        chk($sformatf("g%0d_wait c%0d", g, cyc), 32'(wreq[g]),
            32'(st_now || (qt.size() == 4 && !ev)));
        chk($sformatf("g%0d_valid c%0d", g, cyc), 32'(rvld[g]), 32'(ev));
        if (ev) begin
          chk($sformatf("g%0d_rdata c%0d", g, cyc), rdata[g], qd[0]);
          void'(qd.pop_front());
          void'(qt.pop_front());
          if (mrd < 65535) mrd++;
        end
        chk($sformatf("g%0d_rd_count", g), 32'(rdc[g]), 32'(mrd));
        chk($sformatf("g%0d_wr_count", g), 32'(wrc[g]), 32'(mwr));
        chk($sformatf("g%0d_addr_error", g), 32'(aerr[g]), 32'(merr));
        st_now = 0;
        if (rst_n === 1'b1 && (rd[g] || wr[g]) && !wreq[g]) begin
          a  = addr[g];
          ok = (a >= LB) && ((a - LB) % 4 == 0) && ((a - LB) / 4 < LD);
          if (wr[g]) begin
            if (ok) mmem[(a - LB) / 4] = wdata[g];
            else merr = 1;
            if (rd[g]) merr = 1;
            if (mwr < 65535) mwr++;
          end else begin
            if (ok) qd.push_back(mmem[(a - LB) / 4]);
            else begin
              qd.push_back(32'h0);
              merr = 1;
            end
            qt.push_back(cyc + int'(LL));
          end
          macc++;
          if (LW != 0 && macc == int'(LW)) begin
            macc   = 0;
            st_now = 1;
          end
        end
      end
    end
  end

  // Called just after a rising edge; leaves strobes asserted so requests can run back to back
  task automatic issue(input int g, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, output int acyc);
    addr[g] = a; wdata[g] = d; wr[g] = w; rd[g] = r;
    acyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!wreq[g]) acyc = cyc;
      @(posedge clk); #1;
      if (acyc >= 0) break;
    end
    if (acyc < 0) chk($sformatf("g%0d_accept_timeout", g), 32'(wreq[g]), 32'd0);
  endtask

  task automatic idle(input int g);
    rd[g] = 1'b0; wr[g] = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int g = 0; g < 3; g++) idle(g);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, c, cl;
    int cs [12];
    logic [31:0] b, a;
    rd = '0; wr = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stall injection on instance 2: 0,0,0,1 waitrequest pattern
    b = base_of(2);
    for (int k = 0; k < 12; k++) issue(2, 1, 0, b + 32'(4 * k), $urandom, cs[k]);
    idle(2);
    for (int k = 0; k < 12; k++)
      chk($sformatf("t4_accept_cycle_%0d", k), 32'(cs[k] - cs[0]), 32'(k + k / 3));
    @(negedge clk);
    chk("t4_stall_after_12", 32'(wreq[2]), 32'd1);
    @(posedge clk); #1;

    // Fill: instance 0 with i-6, instances 1 and 2 with random data
    for (int i = 0; i < 64; i++) issue(0, 1, 0, base_of(0) + 32'(4 * i), 32'(i - 6), c);
    idle(0);
    chk("t1_wr_count", 32'(wrc[0]), 32'd64);
    for (int g = 1; g < 3; g++) begin
      for (int i = 0; i < 64; i++) issue(g, 1, 0, base_of(g) + 32'(4 * i), $urandom, c);
      idle(g);
    end
    drain(2);

    // 64 back-to-back reads
    for (int i = 0; i < 64; i++) begin
      issue(0, 0, 1, base_of(0) + 32'(4 * i), 32'h0, c);
      if (i == 0) c0 = c;
    end
    chk("t1_read_span", 32'(c - c0), 32'd63);
    drain(4);
    chk("t1_rd_count", 32'(rdc[0]), 32'd64);

    // Outstanding limit with latency 6
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 1, base_of(1) + 32'(4 * i), 32'h0, cs[i]);
    end
    for (int i = 1; i < 5; i++)
      chk($sformatf("t2_accept_cycle_%0d", i), 32'(cs[i] - cs[0]), (i == 4) ? 32'd6 : 32'(i));
    drain(10);

    // Invalid addresses
    issue(0, 1, 0, base_of(0) + 32'(4 * 1024), 32'hDEAD_BEEF, c);
    idle(0);
    chk("t3_err_set", 32'(aerr[0]), 32'd1);
    issue(0, 0, 1, base_of(0), 32'h0, c);
    issue(0, 0, 1, base_of(0) + 32'd2, 32'h0, c);
    drain(4);

    // Read snapshot versus following write
    a = base_of(0) + 32'd40;
    issue(0, 1, 0, a, 32'd5, c);
    issue(0, 0, 1, a, 32'h0, c);
    issue(0, 1, 0, a, 32'd9, c);
    issue(0, 0, 1, a, 32'h0, c);
    drain(4);
    chk("t3_err_sticky", 32'(aerr[0]), 32'd1);

    // Simultaneous read and write
    chk("t7_err_clean", 32'(aerr[1]), 32'd0);
    issue(1, 1, 1, base_of(1) + 32'd80, 32'h77, c);
    drain(8);
    chk("t7_err_set", 32'(aerr[1]), 32'd1);
    chk("t7_no_return", 32'(rdc[1]), 32'd5);
    issue(1, 0, 1, base_of(1) + 32'd80, 32'h0, c);
    drain(8);

    // Reset with reads in flight
    issue(0, 0, 1, base_of(0), 32'h0, c);
    issue(0, 0, 1, base_of(0) + 32'd4, 32'h0, c);
    idle(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_wait_in_reset", 32'(wreq[0]), 32'd1);
    chk("t6_rd_count", 32'(rdc[0]), 32'd0);
    @(posedge clk); #1;
    drain(8);
    for (int i = 0; i < 4; i++) issue(0, 0, 1, base_of(0) + 32'(4 * i), 32'h0, c);
    drain(4);

    // Random traffic on each instance
    for (int g = 0; g < 3; g++) begin
      b = base_of(g);
      for (int n = 0; n < 250; n++) begin
        int op;
        op = int'($urandom_range(0, 9));
        a  = b + 32'(4 * $urandom_range(0, 63));
        if (op == 9) begin
          case ($urandom_range(0, 2))
            0: a = a + 32'($urandom_range(1, 3));
            1: a = b + 32'(4 * depth_of(g)) + 32'(4 * $urandom_range(0, 7));
            default: a = (b == 0) ? 32'hFFFF_FFFC : b - 32'd4;
          endcase
        end
        if (op < 2) begin
          idle(g);
          @(posedge clk); #1;
        end else if (op < 6) begin
          issue(g, 0, 1, a, 32'h0, c);
        end else begin
          issue(g, (op != 9) || ($urandom_range(0, 1) == 1), (op == 9) ? 1'b0 : 1'b0, a, $urandom, c);
          if (op == 9 && !wr[g]) idle(g);
        end
        if (op == 9 && !wr[g]) begin
          issue(g, 0, 1, a, 32'h0, cl);
        end
      end
      drain(12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
